gray_stream_checker: RTL and testbench

- Downstream consumer of the free-running Gray-code counter stage.
- Takes the counter's gray_cnt bus and its wrap pulse sig, and delays both through SYNC_STAGES flops.
- Decodes Gray to binary, checks that the sequence advances legally, and counts wraps.
- Flags any discontinuity or any misplaced wrap pulse to the monitor/assertion layer.

---
 rtl/gray_stream_checker_if.sv | 26 ++
 rtl/gray_stream_checker.sv | 124 ++++++++++++
 tb/tb_gray_stream_checker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_stream_checker_if.sv
// Bus between a Gray-code counter stage (master) and gray_stream_checker (slave).
// The master drives the Gray count, wrap pulse and error clear; the checker returns decode and status.
interface gray_stream_checker_if #(
   parameter int CBITS     = 18,
   parameter int WRAP_BITS = 8
);
   logic [CBITS-1:0]     gray_in;
   logic                 sig_in;
   logic                 clr_err;
   logic [CBITS-1:0]     bin_out;
   logic                 bin_valid;
   logic [WRAP_BITS-1:0] wrap_cnt;
   logic                 step_err;
   logic                 sig_err;
   logic                 err_sticky;

   modport master (
      output gray_in, sig_in, clr_err,
      input  bin_out, bin_valid, wrap_cnt, step_err, sig_err, err_sticky
   );

   modport slave (
      input  gray_in, sig_in, clr_err,
      output bin_out, bin_valid, wrap_cnt, step_err, sig_err, err_sticky
   );
endinterface

// File: rtl/gray_stream_checker.sv
// Delays, decodes and checks a Gray-code count stream, counting wraps and flagging bad steps/wrap pulses.
// Define GRAY_STRICT_ADVANCE_EN to treat a held count as an illegal step.
module gray_stream_checker #(
   parameter int CBITS       = 18,
   parameter int WRAP_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   gray_stream_checker_if.slave io_bus
);

`ifdef GRAY_STRICT_ADVANCE_EN
   localparam bit HOLD_LEGAL = 1'b0;
`else
   localparam bit HOLD_LEGAL = 1'b1;
`endif

   typedef enum logic [1:0] {S_INIT, S_TRACK, S_RESYNC} state_t;

   function automatic logic [CBITS-1:0] gray2bin(input logic [CBITS-1:0] g);
      logic [CBITS-1:0] b;
      b[CBITS-1] = g[CBITS-1];
      for (int i = CBITS - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [CBITS-1:0]     r_gray_d [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] r_sig_d;
   logic [CBITS-1:0]     r_bin_out;
   logic                 r_valid;
   logic [WRAP_BITS-1:0] r_wrap_cnt;
   logic                 r_step_err;
   logic                 r_sig_err;
   logic                 r_sticky;
   logic [2:0]           r_init_cnt;
   state_t               r_state;

   state_t               w_state_nx;
   logic [CBITS-1:0]     w_dec;
   logic                 w_sig_al;
   logic                 w_hold;
   logic                 w_inc;
   logic                 w_wrap;
   logic                 w_step_err;
   logic                 w_sig_err;

   // Input delay line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_gray_d[i] <= '0;
         r_sig_d <= '0;
      end else begin
         r_gray_d[0] <= io_bus.gray_in;
         r_sig_d[0]  <= io_bus.sig_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_gray_d[i] <= r_gray_d[i-1];
            r_sig_d[i]  <= r_sig_d[i-1];
         end
      end
   end

   // r_bin_out doubles as the previous-value register for the step check
   assign w_dec    = gray2bin(r_gray_d[SYNC_STAGES-1]);
   assign w_sig_al = r_sig_d[SYNC_STAGES-1];
   assign w_hold   = (w_dec == r_bin_out);
   assign w_inc    = (w_dec == r_bin_out + CBITS'(1));

   always_comb begin
      w_state_nx = r_state;
      w_wrap     = 1'b0;
      w_step_err = 1'b0;
      w_sig_err  = 1'b0;
      case (r_state)
         S_INIT: begin
            if (r_init_cnt == 3'(SYNC_STAGES)) w_state_nx = S_TRACK;
         end
         S_TRACK: begin
            w_wrap     = (&r_bin_out) && (w_dec == '0);
            w_step_err = !(w_inc || (HOLD_LEGAL && w_hold));
            // A wrap pulse on a legal hold at zero repeats the pulse of the original wrap
            w_sig_err  = (w_sig_al && (w_dec != '0)) ||
                         (w_wrap && !w_sig_al) ||
                         (w_sig_al && (w_dec == '0) && !w_wrap && !(HOLD_LEGAL && w_hold));
            if (w_step_err) w_state_nx = S_RESYNC;
         end
         S_RESYNC: w_state_nx = S_TRACK;
         default:  w_state_nx = S_INIT;
      endcase
   end

   // Decode/check stage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_INIT;
         r_init_cnt <= '0;
         r_bin_out  <= '0;
         r_valid    <= 1'b0;
         r_step_err <= 1'b0;
         r_sig_err  <= 1'b0;
         r_sticky   <= 1'b0;
         r_wrap_cnt <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + 3'd1 : 3'd0;
         r_bin_out  <= w_dec;
         r_valid    <= (w_state_nx == S_TRACK);
         r_step_err <= w_step_err;
         r_sig_err  <= w_sig_err;
         if (w_step_err || w_sig_err) r_sticky <= 1'b1;
         else if (io_bus.clr_err)     r_sticky <= 1'b0;
         if (io_bus.clr_err)                  r_wrap_cnt <= WRAP_BITS'(w_wrap);
         else if (w_wrap && !(&r_wrap_cnt))   r_wrap_cnt <= r_wrap_cnt + WRAP_BITS'(1);
      end
   end

   assign io_bus.bin_out    = r_bin_out;
   assign io_bus.bin_valid  = r_valid;
   assign io_bus.wrap_cnt   = r_wrap_cnt;
   assign io_bus.step_err   = r_step_err;
   assign io_bus.sig_err    = r_sig_err;
   assign io_bus.err_sticky = r_sticky;

endmodule

// File: tb/tb_gray_stream_checker.sv
// Scoreboard bench for gray_stream_checker with CBITS=4, WRAP_BITS=2, SYNC_STAGES=2.
module tb_gray_stream_checker;
   localparam int CB   = 4;
   localparam int WB   = 2;
   localparam int SS   = 2;
   localparam int CMOD = 1 << CB;
   localparam int WMAX = (1 << WB) - 1;
`ifdef GRAY_STRICT_ADVANCE_EN
   localparam bit HOLD_OK = 1'b0;
`else
   localparam bit HOLD_OK = 1'b1;
`endif

   typedef struct {
      int bin; int vld; int wrp; int se; int ge; int stk;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   int   c = 0;
   exp_t sb_q[$];

   // reference model state
   int   m_pipe[SS];
   bit   m_spipe[SS];
   int   m_state, m_cnt, m_bin, m_wrapc;
   bit   m_stk;

   gray_stream_checker_if #(.CBITS(CB), .WRAP_BITS(WB)) bus ();

   gray_stream_checker #(.CBITS(CB), .WRAP_BITS(WB), .SYNC_STAGES(SS)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SS; i++) begin m_pipe[i] = 0; m_spipe[i] = 1'b0; end
      m_state = 0; m_cnt = 0; m_bin = 0; m_wrapc = 0; m_stk = 1'b0;
      sb_q.delete();
   endtask

   // One clock edge of the checker, as the behaviour describes it, from the stimulus history
   task automatic model_edge(input int v, input bit s, input bit clr);
      int   dec, nst;
      bit   sg, st, ge, wr, hold, nxt;
      exp_t e;
      dec = m_pipe[SS-1];
      sg  = m_spipe[SS-1];
      st = 0; ge = 0; wr = 0;
      nst = m_state;
      if (m_state == 1) begin
         hold = (dec == m_bin);
         nxt  = (dec == (m_bin + 1) % CMOD);
         wr   = (m_bin == CMOD - 1) && (dec == 0);
         st   = !(nxt || (hold && HOLD_OK));
         ge   = (sg && dec != 0) || (wr && !sg) || (sg && dec == 0 && !wr && !(hold && HOLD_OK));
         if (st) nst = 2;
      end else if (m_state == 0) begin
         if (m_cnt == SS) nst = 1;
      end else begin
         nst = 1;
      end
      m_cnt = (m_state == 0) ? m_cnt + 1 : 0;
      if (st || ge) m_stk = 1'b1;
      else if (clr) m_stk = 1'b0;
      if (clr) m_wrapc = wr ? 1 : 0;
      else if (wr && m_wrapc < WMAX) m_wrapc++;
      m_bin   = dec;
      m_state = nst;
      for (int i = SS - 1; i > 0; i--) begin
         m_pipe[i]  = m_pipe[i-1];
         m_spipe[i] = m_spipe[i-1];
      end
      m_pipe[0] = v; m_spipe[0] = s;
      e.bin = dec; e.vld = (nst == 1); e.wrp = m_wrapc;
      e.se = st; e.ge = ge; e.stk = m_stk;
      sb_q.push_back(e);
   endtask

   task automatic cyc(input int v, input bit s, input bit clr);
      exp_t e;
      bus.gray_in = CB'(v ^ (v >> 1));
      bus.sig_in  = s;
      bus.clr_err = clr;
      model_edge(v, s, clr);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check("bin_out",    int'(bus.bin_out),    e.bin);
         check("bin_valid",  int'(bus.bin_valid),  e.vld);
         check("wrap_cnt",   int'(bus.wrap_cnt),   e.wrp);
         check("step_err",   int'(bus.step_err),   e.se);
         check("sig_err",    int'(bus.sig_err),    e.ge);
         check("err_sticky", int'(bus.err_sticky), e.stk);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(c, c == 0, 1'b0);
         c = (c + 1) % CMOD;
      end
   endtask

   task automatic run_until(input int t);
      int last;
      for (int i = 0; i < CMOD; i++) begin
         last = c;
         cyc(c, c == 0, 1'b0);
         c = (c + 1) % CMOD;
         if (last == t) break;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_bin"},  int'(bus.bin_out),    0);
      check({tag, "_vld"},  int'(bus.bin_valid),  0);
      check({tag, "_wrap"}, int'(bus.wrap_cnt),   0);
      check({tag, "_se"},   int'(bus.step_err),   0);
      check({tag, "_ge"},   int'(bus.sig_err),    0);
      check({tag, "_stk"},  int'(bus.err_sticky), 0);
   endtask

   initial begin
      int wexp[5];
      wexp = '{1, 2, 3, 3, 3};
      bus.gray_in = '0; bus.sig_in = 1'b0; bus.clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // INIT latency then a full lap with wrap
      run(2);
      check("vld_init", int'(bus.bin_valid), 0);
      run(1);
      check("vld_rise", int'(bus.bin_valid), 1);
      run(17);
      check("wrap_first", int'(bus.wrap_cnt), 1);
      check("clean_lap",  int'(bus.err_sticky), 0);

      // skip 4 -> 7
      cyc(4, 1'b0, 1'b0);
      cyc(7, 1'b0, 1'b0);
      c = 6;
      run(8);
      check("skip_stk", int'(bus.err_sticky), 1);
      cyc(c, 1'b0, 1'b1);
      c = (c + 1) % CMOD;
      run(1);
      check("skip_clr", int'(bus.err_sticky), 0);

      // stray wrap pulse at 9
      run_until(8);
      cyc(9, 1'b1, 1'b0);
      c = 10;
      run(4);
      check("sig_stk", int'(bus.err_sticky), 1);
      cyc(c, 1'b0, 1'b1);
      c = (c + 1) % CMOD;
      check("sig_clr", int'(bus.err_sticky), 0);
      run(2);

      // saturation of the wrap counter, then clear on a wrap
      for (int i = 0; i < 5; i++) begin
         run_until(2);
         check("wrap_sat", int'(bus.wrap_cnt), wexp[i]);
      end
      run_until(1);
      cyc(2, 1'b0, 1'b1);
      c = 3;
      check("wrap_clr", int'(bus.wrap_cnt), 1);

      // hold at 6
      run_until(6);
      cyc(6, 1'b0, 1'b0);
      run_until(9);
      check("hold_stk", int'(bus.err_sticky), HOLD_OK ? 0 : 1);

      // mid-stream reset with bin_out=11 and an error latched
      run_until(9);
      cyc(10, 1'b1, 1'b0);
      c = 11;
      run_until(13);
      check("pre_rst_bin", int'(bus.bin_out), 11);
      check("pre_rst_stk", int'(bus.err_sticky), 1);
      rst = 1'b1;
      #1;
      check_zero("midrst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      c = 0;
      run(2);
      check("vld_reinit", int'(bus.bin_valid), 0);
      run(1);
      check("vld_rerise", int'(bus.bin_valid), 1);
      run(6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
